vec_mul_sequencer: RTL and testbench
====================================

VEC_MUL_SEQUENCER -- requirements
Module: vec_mul_sequencer

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10, UB/result SRAM address width.
REQ-002 SHALL have parameter LEN_W, default 8, width of the vector-count field.
REQ-003 SHALL have parameter PIPE_LAT, default 3, cycles from UB address issue to valid multiplier result (range 1..16).
REQ-004 SHALL have ports, clock and reset first: clk in 1 clock; rstn in 1 reset, synchronous and active-high (1 = reset).
REQ-005 SHALL have ports: start in 1 job request; weight_reload_req in 1 load fresh weights for this job; src_base in ADDRESSSIZE first UB address; dst_base in ADDRESSSIZE first result address; num_vec in LEN_W vector count.
REQ-006 SHALL have ports: fifo_empty in 1; fifo_read_enable out 1; weight_reload out 1; ub_read_en out 1; ub_address out ADDRESSSIZE.
REQ-007 SHALL have ports: res_write_enable out 1; res_address out ADDRESSSIZE; busy out 1; done out 1 (one-cycle pulse); err_no_weight out 1 (sticky).

Function
REQ-008 SHALL implement FSM IDLE, WLOAD, RUN, DRAIN, FIN.
REQ-009 IDLE: start=1 and num_vec!=0 SHALL latch src_base, dst_base and num_vec, then go to WLOAD if weight_reload_req=1, else to RUN; start with num_vec=0 SHALL pulse done next cycle with no reads or writes.
REQ-010 WLOAD: fifo_empty=0 SHALL assert fifo_read_enable and weight_reload for exactly one cycle, then go to RUN; fifo_empty=1 SHALL set err_no_weight and return to IDLE with no done pulse.
REQ-011 RUN SHALL assert ub_read_en for exactly num_vec consecutive cycles with ub_address = src_base + k for k = 0..num_vec-1, modulo 2^ADDRESSSIZE (wraps).
REQ-012 A PIPE_LAT-deep valid shift register SHALL delay ub_read_en; its output drives res_write_enable.
REQ-013 res_address SHALL equal dst_base + j, modulo 2^ADDRESSSIZE, for the j-th asserted res_write_enable; exactly num_vec writes SHALL occur.
REQ-014 After the last read, the FSM SHALL go to DRAIN and stay there until the valid shift register is empty, then go to FIN.
REQ-015 FIN SHALL pulse done for one cycle and return to IDLE; done SHALL rise exactly PIPE_LAT+1 cycles after the last ub_read_en.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 start while busy=1 SHALL be ignored (no queueing).
REQ-018 err_no_weight SHALL clear only on reset or on the next accepted start.

Reset
REQ-019 rstn=1 at a clk edge SHALL force IDLE, clear the valid pipeline and latched registers, and drive every output to 0, including mid-job (in-flight writes are dropped).
REQ-020 No res_write_enable SHALL assert in the first cycle after reset deasserts.

Configuration
REQ-021 With VEC_MUL_PERF_CNT_EN defined, SHALL add output cycle_count (32 bits): cleared on accepted start, incremented every busy cycle, held after done, saturating at all-ones.
REQ-022 Without VEC_MUL_PERF_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-023 The FSM state enum and the PIPE_LAT bounds constants SHALL live in shared package vec_mul_pkg.
REQ-024 The valid delay line SHALL be a sub-module valid_delay_line, parameterised by depth.

Verification
REQ-025 PIPE_LAT=3, src_base=5, dst_base=20, num_vec=4, no reload: reads at 5..8 on cycles t..t+3; writes at 20..23 on t+3..t+6; done at t+7.
REQ-026 weight_reload_req=1, fifo_empty=0: fifo_read_enable and weight_reload high one cycle, then RUN; repeat with fifo_empty=1: err_no_weight=1, no done, busy returns to 0.
REQ-027 ADDRESSSIZE=10, src_base=1022, num_vec=4: ub_address sequence 1022, 1023, 0, 1.
REQ-028 num_vec=0: done one cycle after start, no ub_read_en or res_write_enable.
REQ-029 rstn=1 during DRAIN with 2 writes pending: all outputs 0 next cycle, no further writes; a new start works normally.
REQ-030 With VEC_MUL_PERF_CNT_EN, the REQ-025 job: cycle_count = 8 after done; a second start while busy: ignored, count unaffected.

Source files
------------

// File: rtl/vec_mul_pkg.sv
// rtl/vec_mul_pkg.sv - shared FSM state type and pipeline-latency bounds
package vec_mul_pkg;

  // Sequencer control states; IDLE is the only non-busy state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WLOAD = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_e;

  // Legal range of the address-to-result latency of the multiplier path.
  localparam int PIPE_LAT_MIN = 1;
  localparam int PIPE_LAT_MAX = 16;

endpackage

// File: rtl/vec_mul_sequencer_if.sv
// rtl/vec_mul_sequencer_if.sv - job, weight FIFO, UB and result-SRAM signals of the sequencer
interface vec_mul_sequencer_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int LEN_W       = 8
);

  logic                   start;
  logic                   weight_reload_req;
  logic [ADDRESSSIZE-1:0] src_base;
  logic [ADDRESSSIZE-1:0] dst_base;
  logic [LEN_W-1:0]       num_vec;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   weight_reload;
  logic                   ub_read_en;
  logic [ADDRESSSIZE-1:0] ub_address;
  logic                   res_write_enable;
  logic [ADDRESSSIZE-1:0] res_address;
  logic                   busy;
  logic                   done;
  logic                   err_no_weight;

  // Master: the job issuer / surrounding datapath that drives requests and FIFO status.
  modport master (
    output start, weight_reload_req, src_base, dst_base, num_vec, fifo_empty,
    input  fifo_read_enable, weight_reload, ub_read_en, ub_address,
           res_write_enable, res_address, busy, done, err_no_weight
  );

  // Slave: the sequencer itself.
  modport slave (
    input  start, weight_reload_req, src_base, dst_base, num_vec, fifo_empty,
    output fifo_read_enable, weight_reload, ub_read_en, ub_address,
           res_write_enable, res_address, busy, done, err_no_weight
  );

endinterface

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - DEPTH-stage valid shift register tracking in-flight multiplier results
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_i,
  input  logic valid_i,
  output logic valid_o,
  output logic pending_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Shift the incoming valid one stage per cycle toward the output.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = valid_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage register; reset drops every in-flight valid.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Pending means something is still upstream of the output stage, so the
  // line will not be empty after the next edge.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending_o = pending_o | pipe_q[i];
    end
  end

  assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vec_mul_sequencer.sv
// rtl/vec_mul_sequencer.sv - vector-multiply job sequencer (optional VEC_MUL_PERF_CNT_EN adds cycle_count)
module vec_mul_sequencer
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int LEN_W       = 8,
  parameter int PIPE_LAT    = 3
) (
  input  logic clk,
  input  logic rstn,
  vec_mul_sequencer_if.slave bus
`ifdef VEC_MUL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count
`endif
);

  seq_state_e             state_q, state_d;
  logic [ADDRESSSIZE-1:0] src_q, src_d;
  logic [ADDRESSSIZE-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]       num_q, num_d;
  logic [LEN_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [ADDRESSSIZE-1:0] wr_cnt_q, wr_cnt_d;
  logic                   err_q, err_d;

  logic rd_en;
  logic fifo_rd;
  logic done_pulse;
  logic wr_en;
  logic pipe_pending;

  // Each UB read returns a product PIPE_LAT cycles later; the delayed
  // read-enable is exactly the result write strobe.
  valid_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_valid_delay (
    .clk      (clk),
    .rst_i    (rstn),
    .valid_i  (rd_en),
    .valid_o  (wr_en),
    .pending_o(pipe_pending)
  );

  // State and job-context registers; rstn is active-high.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      num_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      num_q    <= num_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    num_d      = num_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    err_d      = err_q;
    rd_en      = 1'b0;
    fifo_rd    = 1'b0;
    done_pulse = 1'b0;

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + ADDRESSSIZE'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        // Start is only looked at here, so a start while busy is dropped.
        if (bus.start) begin
          err_d = 1'b0;
          if (bus.num_vec != '0) begin
            src_d    = bus.src_base;
            dst_d    = bus.dst_base;
            num_d    = bus.num_vec;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            state_d  = bus.weight_reload_req ? ST_WLOAD : ST_RUN;
          end else begin
            // Empty job: acknowledge with done and touch no memory.
            state_d = ST_FIN;
          end
        end
      end

      ST_WLOAD: begin
        if (!bus.fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = ST_RUN;
        end else begin
          // No weights available: abort silently, flag stays until next start.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        rd_en    = 1'b1;
        rd_cnt_d = rd_cnt_q + LEN_W'(1);
        if (rd_cnt_q == num_q - LEN_W'(1)) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Leave once only the output stage (or nothing) is still valid, so
        // FIN lands the cycle after the final write.
        if (!pipe_pending) begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        done_pulse = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ub_read_en       = rd_en;
  assign bus.ub_address       = rd_en ? (src_q + ADDRESSSIZE'(rd_cnt_q)) : '0;
  assign bus.res_write_enable = wr_en;
  assign bus.res_address      = wr_en ? (dst_q + wr_cnt_q) : '0;
  assign bus.fifo_read_enable = fifo_rd;
  assign bus.weight_reload    = fifo_rd;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.done             = done_pulse;
  assign bus.err_no_weight    = err_q;

`ifdef VEC_MUL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;

  // Busy-cycle counter: restarts on an accepted start, holds once idle, saturates.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cycle_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && bus.start) begin
      cycle_cnt_q <= '0;
    end else if ((state_q != ST_IDLE) && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign cycle_count = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// tb/tb_vec_mul_sequencer.sv - self-checking bench for vec_mul_sequencer
module tb_vec_mul_sequencer;

  localparam int AW = 10;
  localparam int LW = 8;
  localparam int P  = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vec_mul_sequencer_if #(.ADDRESSSIZE(AW), .LEN_W(LW)) bus ();

`ifdef VEC_MUL_PERF_CNT_EN
  logic [31:0] cycle_count;
`endif

  vec_mul_sequencer #(
    .ADDRESSSIZE(AW),
    .LEN_W      (LW),
    .PIPE_LAT   (P)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
`ifdef VEC_MUL_PERF_CNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] n;
    bit            rl;
    bit            fe;
    bit            spur;
    int            exp_done;
    int            exp_wr;
    bit            exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag, input int cyc);
    chk({tag, ".ub_read_en"}, cyc, 32'(bus.ub_read_en), 0);
    chk({tag, ".ub_address"}, cyc, 32'(bus.ub_address), 0);
    chk({tag, ".res_write_enable"}, cyc, 32'(bus.res_write_enable), 0);
    chk({tag, ".res_address"}, cyc, 32'(bus.res_address), 0);
    chk({tag, ".fifo_read_enable"}, cyc, 32'(bus.fifo_read_enable), 0);
    chk({tag, ".weight_reload"}, cyc, 32'(bus.weight_reload), 0);
    chk({tag, ".busy"}, cyc, 32'(bus.busy), 0);
    chk({tag, ".done"}, cyc, 32'(bus.done), 0);
    chk({tag, ".err_no_weight"}, cyc, 32'(bus.err_no_weight), 0);
`ifdef VEC_MUL_PERF_CNT_EN
    chk({tag, ".cycle_count"}, cyc, cycle_count, 0);
`endif
  endtask

  // Runs one job from an idle sequencer and compares every cycle against the
  // timeline implied by the job rules: first read one cycle after start (two
  // with a weight load), results P cycles after each read, done P+1 after the
  // last read, busy from the cycle after start through done.
  task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [LW-1:0] n,
                         input bit rl, input bit fe, input bit spur,
                         output int done_cyc, output int n_rd, output int n_wr, output bit err_end);
    int  t, last, e_done_cyc, busy_cnt, nn;
    bit  wl, bad, e_rd, e_wr, e_busy, e_fifo, e_err;
    nn  = int'(n);
    wl  = rl && (nn != 0);
    bad = wl && fe;
    t   = 1 + (wl ? 1 : 0);
    if (nn == 0)  e_done_cyc = 1;
    else if (bad) e_done_cyc = -1;
    else          e_done_cyc = t + nn + P;
    last = bad ? 4 : (e_done_cyc + 2);
    done_cyc = 0; n_rd = 0; n_wr = 0; busy_cnt = 0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.src_base = src;
    bus.dst_base = dst;
    bus.num_vec = n;
    bus.weight_reload_req = rl;
    bus.fifo_empty = fe;

    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      e_rd   = !bad && (nn != 0) && (i >= t) && (i < t + nn);
      e_wr   = !bad && (nn != 0) && (i >= t + P) && (i < t + P + nn);
      e_busy = bad ? (i == 1) : (i <= e_done_cyc);
      e_fifo = wl && !fe && (i == 1);
      e_err  = bad && (i >= 2);
      if (e_busy) busy_cnt++;

      chk("ub_read_en", i, 32'(bus.ub_read_en), 32'(e_rd));
      if (e_rd) chk("ub_address", i, 32'(bus.ub_address), (int'(src) + (i - t)) % (1 << AW));
      chk("res_write_enable", i, 32'(bus.res_write_enable), 32'(e_wr));
      if (e_wr) chk("res_address", i, 32'(bus.res_address), (int'(dst) + (i - t - P)) % (1 << AW));
      chk("done", i, 32'(bus.done), 32'(i == e_done_cyc));
      chk("busy", i, 32'(bus.busy), 32'(e_busy));
      chk("fifo_read_enable", i, 32'(bus.fifo_read_enable), 32'(e_fifo));
      chk("weight_reload", i, 32'(bus.weight_reload), 32'(e_fifo));
      chk("err_no_weight", i, 32'(bus.err_no_weight), 32'(e_err));

      if (bus.ub_read_en === 1'b1) n_rd++;
      if (bus.res_write_enable === 1'b1) n_wr++;
      if (bus.done === 1'b1 && done_cyc == 0) done_cyc = i;
      err_end = bus.err_no_weight;

      if (i == 1) bus.start = 1'b0;
      if (spur && i == 2) begin
        bus.start = 1'b1;
        bus.src_base = AW'($urandom);
        bus.dst_base = AW'($urandom);
        bus.num_vec = LW'($urandom_range(1, 255));
      end
      if (spur && i == 3) bus.start = 1'b0;
    end
`ifdef VEC_MUL_PERF_CNT_EN
    chk("cycle_count", last, cycle_count, busy_cnt);
`endif
  endtask

  initial begin
    int  dc, nr, nw;
    bit  er;
    bus.start = 1'b0;
    bus.weight_reload_req = 1'b0;
    bus.src_base = '0;
    bus.dst_base = '0;
    bus.num_vec = '0;
    bus.fifo_empty = 1'b1;

    //            src   dst   n    rl fe sp done  wr   err
    vecs[0] = '{10'd5,    10'd20,   8'd4,   0, 0, 1, 8,   4,   0};
    vecs[1] = '{10'd1022, 10'd1020, 8'd4,   0, 0, 0, 8,   4,   0};
    vecs[2] = '{10'd7,    10'd9,    8'd0,   0, 0, 0, 1,   0,   0};
    vecs[3] = '{10'd100,  10'd200,  8'd2,   1, 0, 1, 7,   2,   0};
    vecs[4] = '{10'd50,   10'd60,   8'd3,   1, 1, 0, 0,   0,   1};
    vecs[5] = '{10'd0,    10'd1023, 8'd1,   0, 0, 0, 5,   1,   0};
    vecs[6] = '{10'd900,  10'd3,    8'd255, 0, 0, 0, 259, 255, 0};
    vecs[7] = '{10'd10,   10'd10,   8'd0,   1, 1, 0, 1,   0,   0};

    // Reset state and the first cycle after release.
    repeat (3) @(negedge clk);
    chk_all_zero("reset", 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("post_reset.res_write_enable", 1, 32'(bus.res_write_enable), 0);
    chk("post_reset.busy", 1, 32'(bus.busy), 0);

    // Directed job table.
    for (int r = 0; r < 8; r++) begin
      run_job(vecs[r].src, vecs[r].dst, vecs[r].n, vecs[r].rl, vecs[r].fe, vecs[r].spur, dc, nr, nw, er);
      chk($sformatf("row%0d.done_cycle", r), r, dc, vecs[r].exp_done);
      chk($sformatf("row%0d.reads", r), r, nr, vecs[r].exp_wr);
      chk($sformatf("row%0d.writes", r), r, nw, vecs[r].exp_wr);
      chk($sformatf("row%0d.err", r), r, 32'(er), 32'(vecs[r].exp_err));
    end

    // Reset while draining with two writes still in flight.
    @(negedge clk);
    bus.start = 1'b1; bus.src_base = 10'd5; bus.dst_base = 10'd20;
    bus.num_vec = 8'd4; bus.weight_reload_req = 1'b0; bus.fifo_empty = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    chk("drain.write_before_reset", 5, 32'(bus.res_write_enable), 1);
    chk("drain.addr_before_reset", 5, 32'(bus.res_address), 21);
    rstn = 1'b1;
    @(negedge clk);
    chk_all_zero("drain_reset", 6);
    rstn = 1'b0;
    for (int i = 7; i <= 11; i++) begin
      @(negedge clk);
      chk("drain.no_write_after_reset", i, 32'(bus.res_write_enable), 0);
      chk("drain.idle_after_reset", i, 32'(bus.busy), 0);
      chk("drain.no_done_after_reset", i, 32'(bus.done), 0);
    end
    run_job(10'd5, 10'd20, 8'd4, 1'b0, 1'b0, 1'b0, dc, nr, nw, er);
    chk("drain.restart_done", 0, dc, 8);
    chk("drain.restart_writes", 0, nw, 4);

    // Randomized jobs against the timeline model.
    for (int r = 0; r < 16; r++) begin
      logic [LW-1:0] n;
      bit rl, fe, sp, bad;
      n   = LW'($urandom_range(0, 12));
      rl  = 1'($urandom_range(0, 1));
      fe  = ($urandom_range(0, 3) == 0);
      bad = rl && fe && (n != 0);
      sp  = (n != 0) && !bad && ($urandom_range(0, 1) == 1);
      run_job(AW'($urandom), AW'($urandom), n, rl, fe, sp, dc, nr, nw, er);
      chk($sformatf("rand%0d.writes", r), r, nw, bad ? 0 : int'(n));
      chk($sformatf("rand%0d.reads", r), r, nr, bad ? 0 : int'(n));
      if (bad) chk($sformatf("rand%0d.no_done", r), r, dc, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
